// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the parallel I/O bank.
//   PIO_OFF_*     : register offsets within a channel, as seen on Address[3:2]
//   PIO_CH_STRIDE : byte distance between consecutive channels
package pio_pkg;

    localparam logic [1:0] PIO_OFF_DOUT = 2'd0;  // DATA_OUT, read/write
    localparam logic [1:0] PIO_OFF_DIN  = 2'd1;  // DATA_IN, read-only
    localparam logic [1:0] PIO_OFF_EDGE = 2'd2;  // EDGE, write-1-to-clear
    localparam logic [1:0] PIO_OFF_IEN  = 2'd3;  // IRQ_EN, read/write

    localparam int PIO_CH_STRIDE = 16;

endpackage

// File: rtl/pio_channel.sv
// pio_channel: one channel of the parallel I/O bank.
//   Holds the output register, a 2-flop input synchroniser plus a delayed
//   copy for rise detection, sticky rising-edge flags and the interrupt mask.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   armed      : rises are only captured while high (from the bank arm counter)
//   wr_en      : store addressed to this channel (already qualified by Hit)
//   off        : register offset (Address[3:2])
//   wr_data    : store data, channel width
//   rd_data    : combinational read of the register selected by off
//   data_in    : external input, asynchronous to clk
//   data_out   : output register
//   pending    : at least one enabled edge flag is set
module pio_channel
    import pio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             wr_en,
    input  logic [1:0]       off,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             pending
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] edge_flags;
    logic [WIDTH-1:0] ien_q;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c_mask;

    // Rises seen before the bank is armed are dropped so that inputs held
    // high through reset do not look like fresh edges.
    assign rise     = s2 & ~prev & {WIDTH{armed}};
    assign w1c_mask = (wr_en && (off == PIO_OFF_EDGE)) ? wr_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1         <= '0;
            s2         <= '0;
            prev       <= '0;
            dout_q     <= '0;
            edge_flags <= '0;
            ien_q      <= '0;
        end else begin
            s1   <= data_in;
            s2   <= s1;
            prev <= s2;
            if (wr_en && (off == PIO_OFF_DOUT)) begin
                dout_q <= wr_data;
            end
            if (wr_en && (off == PIO_OFF_IEN)) begin
                ien_q <= wr_data;
            end
            // The set term is OR-ed in last so a rise beats a same-cycle clear.
            edge_flags <= (edge_flags & ~w1c_mask) | rise;
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            PIO_OFF_DOUT: rd_data = dout_q;
            PIO_OFF_DIN:  rd_data = s2;
            PIO_OFF_EDGE: rd_data = edge_flags;
            PIO_OFF_IEN:  rd_data = ien_q;
            default:      rd_data = '0;
        endcase
    end

    assign data_out = dout_q;
    assign pending  = |(edge_flags & ien_q);

endmodule

// File: rtl/parallel_io_bank.sv
// parallel_io_bank: memory-mapped parallel I/O peripheral with N_CH channels.
//   Sits on the data-memory bus; the core selects RD whenever Hit is high.
//   Each channel occupies a 16-byte slot: DATA_OUT, DATA_IN, EDGE, IRQ_EN.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   Address   : byte address; window match drives Hit
//   WE, WD    : store strobe and data (low WIDTH bits used)
//   RD        : combinational read data, zero-extended, 0 when Hit is low
//   Hit       : Address is inside this block's window
//   DataIn    : external inputs, channel c at [c*WIDTH +: WIDTH]
//   DataOut   : output registers, same packing
//   IRQ       : registered OR of all pending enabled edge flags
module parallel_io_bank
    import pio_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter int          WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           Address,
    input  logic                  WE,
    input  logic [31:0]           WD,
    output logic [31:0]           RD,
    output logic                  Hit,
    input  logic [N_CH*WIDTH-1:0] DataIn,
    output logic [N_CH*WIDTH-1:0] DataOut,
    output logic                  IRQ
);

    // A single-channel bank still needs a 1-bit select vector; it is tied 0.
    localparam int          CH_BITS  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [31:0] WIN_MASK = 32'(N_CH * PIO_CH_STRIDE - 1);

    logic [CH_BITS-1:0] ch_sel;
    logic [1:0]         off;
    logic [1:0]         arm_cnt;
    logic               armed;
    logic [N_CH-1:0]    pending;
    logic [WIDTH-1:0]   ch_rd [N_CH];

    // Byte-lane bits of the address and the upper store-data bits carry no
    // meaning here; they are folded into a sink so every input bit is read.
    logic unused_bits;
    assign unused_bits = &{1'b0, Address[1:0], WD};

    assign Hit    = (Address & ~WIN_MASK) == BASE_ADDR;
    assign off    = Address[3:2];
    assign ch_sel = (N_CH > 1) ? Address[4 +: CH_BITS] : '0;
    assign armed  = (arm_cnt == 2'd3);

    // Arm counter: saturates at 3, reached on the third edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt <= 2'd0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 2'd1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic ch_wr;
        assign ch_wr = WE && Hit && (ch_sel == CH_BITS'(c));

        pio_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .armed    (armed),
            .wr_en    (ch_wr),
            .off      (off),
            .wr_data  (WD[WIDTH-1:0]),
            .rd_data  (ch_rd[c]),
            .data_in  (DataIn[c*WIDTH +: WIDTH]),
            .data_out (DataOut[c*WIDTH +: WIDTH]),
            .pending  (pending[c])
        );
    end

    always_comb begin
        RD = '0;
        if (Hit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_sel == CH_BITS'(c)) begin
                    RD[WIDTH-1:0] = ch_rd[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= |pending;
        end
    end

endmodule

// File: tb/tb_parallel_io_bank.sv
// Testbench for parallel_io_bank (N_CH=2, WIDTH=8, BASE_ADDR=0x100).
module tb_parallel_io_bank;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Hit;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        IRQ;

    int checks;
    int failures;

    parallel_io_bank #(
        .N_CH      (2),
        .WIDTH     (8),
        .BASE_ADDR (32'h0000_0100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Address (Address),
        .WE      (WE),
        .WD      (WD),
        .RD      (RD),
        .Hit     (Hit),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .IRQ     (IRQ)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [15:0] exp_dout;
    } vec_t;

    localparam int N_VEC = 28;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        WD      = d;
        WE      = 1'b1;
        tick();
        WE      = 1'b0;
        WD      = 32'h0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        Address = a;
        #1;
        check(name, RD, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        Address  = 32'h0;
        WE       = 1'b0;
        WD       = 32'h0;
        DataIn   = 16'h0;

        //           we    addr          wd            exp_rd        hit   dout
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[2]  = '{1'b0, 32'h0000_0108, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 32'h0000_010C, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[4]  = '{1'b0, 32'h0000_0110, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[5]  = '{1'b0, 32'h0000_0114, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 32'h0000_0118, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[7]  = '{1'b0, 32'h0000_011C, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 32'h0000_0200, 32'h0,        32'h0,        1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 32'h0000_00F0, 32'h0,        32'h0,        1'b0, 16'h0000};
        vecs[10] = '{1'b0, 32'h0000_0120, 32'h0,        32'h0,        1'b0, 16'h0000};
        vecs[11] = '{1'b1, 32'h0000_0110, 32'hFFFF_FFA5, 32'h0,       1'b1, 16'hA500};
        vecs[12] = '{1'b0, 32'h0000_0110, 32'h0,        32'h0000_00A5, 1'b1, 16'hA500};
        vecs[13] = '{1'b1, 32'h0000_0100, 32'h0000_003C, 32'h0,       1'b1, 16'hA53C};
        vecs[14] = '{1'b1, 32'h0000_0104, 32'h0000_00FF, 32'h0,       1'b1, 16'hA53C};
        vecs[15] = '{1'b0, 32'h0000_0104, 32'h0,        32'h0,        1'b1, 16'hA53C};
        vecs[16] = '{1'b1, 32'h0000_0200, 32'h0000_0077, 32'h0,       1'b0, 16'hA53C};
        vecs[17] = '{1'b1, 32'h0000_0120, 32'h0000_0055, 32'h0,       1'b0, 16'hA53C};
        vecs[18] = '{1'b0, 32'h0000_0113, 32'h0,        32'h0000_00A5, 1'b1, 16'hA53C};
        vecs[19] = '{1'b0, 32'h0000_0101, 32'h0,        32'h0000_003C, 1'b1, 16'hA53C};
        vecs[20] = '{1'b1, 32'h0000_010C, 32'h0000_000F, 32'h0,       1'b1, 16'hA53C};
        vecs[21] = '{1'b0, 32'h0000_010C, 32'h0,        32'h0000_000F, 1'b1, 16'hA53C};
        vecs[22] = '{1'b1, 32'h0000_011C, 32'h0000_00F0, 32'h0,       1'b1, 16'hA53C};
        vecs[23] = '{1'b0, 32'h0000_011C, 32'h0,        32'h0000_00F0, 1'b1, 16'hA53C};
        vecs[24] = '{1'b0, 32'h0000_010C, 32'h0,        32'h0000_000F, 1'b1, 16'hA53C};
        vecs[25] = '{1'b1, 32'h0000_010C, 32'h0,        32'h0000_000F, 1'b1, 16'hA53C};
        vecs[26] = '{1'b1, 32'h0000_011C, 32'h0,        32'h0000_00F0, 1'b1, 16'hA53C};
        vecs[27] = '{1'b0, 32'h0000_010C, 32'h0,        32'h0,        1'b1, 16'hA53C};

        // Reset state
        tick();
        tick();
        check("rst_dout", 32'(DataOut), 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        rst = 1'b1;
        tick();

        // Table-driven register accesses
        for (int i = 0; i < N_VEC; i++) begin
            Address = vecs[i].addr;
            WD      = vecs[i].wd;
            WE      = vecs[i].we;
            #1;
            check($sformatf("vec%0d_rd", i), RD, vecs[i].exp_rd);
            check($sformatf("vec%0d_hit", i), 32'(Hit), 32'(vecs[i].exp_hit));
            tick();
            WE = 1'b0;
            check($sformatf("vec%0d_dout", i), 32'(DataOut), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_irq", i), 32'(IRQ), 32'h0);
        end

        // Edge capture latency on ch0: drive 0x81 before edge k
        DataIn[7:0] = 8'h81;
        tick();                                    // edge k
        read_check("din_k", 32'h104, 32'h0);
        tick();                                    // edge k+1
        read_check("din_k1", 32'h104, 32'h81);
        read_check("edge_k1", 32'h108, 32'h0);
        tick();                                    // edge k+2
        read_check("edge_k2", 32'h108, 32'h81);
        tick();
        check("irq_masked", 32'(IRQ), 32'h0);

        // Enable bit 0 on a pending flag, then W1C one bit at a time
        bus_write(32'h10C, 32'h01);
        tick();
        check("irq_enabled", 32'(IRQ), 32'h1);
        bus_write(32'h108, 32'h01);
        read_check("edge_w1c0", 32'h108, 32'h80);
        check("irq_before_drop", 32'(IRQ), 32'h1);
        tick();
        check("irq_dropped", 32'(IRQ), 32'h0);
        bus_write(32'h108, 32'h80);
        read_check("edge_w1c7", 32'h108, 32'h0);
        bus_write(32'h108, 32'h00);
        read_check("edge_w0_noop", 32'h108, 32'h0);

        // Rise on bit 2 collides with W1C of bit 2 at edge k+2: set wins
        DataIn[7:0] = 8'h85;
        tick();                                    // edge k
        tick();                                    // edge k+1
        bus_write(32'h108, 32'h04);                // commits at edge k+2
        read_check("set_wins", 32'h108, 32'h04);
        check("irq_bit2_masked", 32'(IRQ), 32'h0);
        bus_write(32'h10C, 32'h04);
        tick();
        check("irq_bit2_enabled", 32'(IRQ), 32'h1);

        // Asynchronous reset mid-stream, away from the clock edge
        #2;
        rst = 1'b0;
        #1;
        check("arst_dout", 32'(DataOut), 32'h0);
        check("arst_irq", 32'(IRQ), 32'h0);
        read_check("arst_edge", 32'h108, 32'h0);
        read_check("arst_ien", 32'h10C, 32'h0);
        read_check("arst_din", 32'h104, 32'h0);

        // Input high through reset must not register an edge
        DataIn = 16'h0008;
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        read_check("held_high_edge", 32'h108, 32'h0);
        read_check("held_high_din", 32'h104, 32'h08);
        DataIn = 16'h0000;
        repeat (3) tick();
        DataIn = 16'h0008;
        tick();
        tick();
        read_check("toggle_edge_k1", 32'h108, 32'h0);
        tick();
        read_check("toggle_edge_k2", 32'h108, 32'h08);
        read_check("toggle_ch1_edge", 32'h118, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parallel_io_bank.md
# parallel_io_bank

Memory-mapped parallel I/O peripheral for the single-cycle core that replaces the fixed 8-bit input/output pair with `N_CH` independent channels of `WIDTH` bits each. Every channel provides an output register, a synchronised input, sticky rising-edge capture and an interrupt mask. The block sits on the data-memory address bus beside `Data_mem`. The core's write-back mux selects `RD` whenever `Hit` is high.

## Interface
- `N_CH`, 2: channel count; power of two, 1..8.
- `WIDTH`, 8: bits per channel, 1..32.
- `BASE_ADDR`, 32'h0000_0100: block base address; aligned to `N_CH*16`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `Address` in 32: byte address from the ULA result.
- `WE` in 1: store strobe (`MemWrite`).
- `WD` in 32: store data (`rd2`); bits `[WIDTH-1:0]` are used, the rest are ignored.
- `RD` out 32: read data, zero-extended; 0 when `Hit`=0.
- `Hit` out 1: `Address` falls inside the block window.
- `DataIn` in `N_CH*WIDTH`: external inputs, asynchronous to `clk`. Channel c occupies `[c*WIDTH +: WIDTH]`.
- `DataOut` out `N_CH*WIDTH`: output registers, same packing as `DataIn`.
- `IRQ` out 1: registered OR of all pending enabled edges.

## Operation
- **Window decode:** `Hit` = (`Address` & ~(`N_CH*16`-1)) == `BASE_ADDR`.
- **Channel select:** c = `Address[4 +: log2(N_CH)]`.
- **Register offset:** `Address[3:2]`; `Address[1:0]` is ignored.
- **Register map (per channel):**
  - 0x0 `DATA_OUT`: read/write; drives `DataOut`.
  - 0x4 `DATA_IN`: read-only; synchronised input. Writes are ignored.
  - 0x8 `EDGE`: sticky rising-edge flags. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0xC `IRQ_EN`: read/write per-bit interrupt mask.
- **Input path:** 2-flop synchroniser `s1`→`s2`, followed by `prev` <= `s2`. A rise is `s2 & ~prev`.
- **Arm counter:** a 2-bit counter is cleared by reset and saturates at 3. Rises are ignored until it reaches 3. This stops inputs that are high through reset from setting `EDGE`.
- **EDGE update:** next = (`EDGE` & ~w1c_mask) | rise. When a rise and a W1C hit the same bit in the same cycle, the set wins.
- **IRQ:** `IRQ` <= OR over c of |(`EDGE[c]` & `IRQ_EN[c]`).
- **Writes:** take effect only when `WE`=1 and `Hit`=1. Non-hitting stores change no state.
- **Reads:** combinational; `RD` = {0, selected register}.
- **Reset (`rst`=0, immediate):** `DataOut`=0, `EDGE`=0, `IRQ_EN`=0, `s1`/`s2`/`prev`=0, arm counter=0, `IRQ`=0. A reset mid-operation discards pending edges and the mask.

## Timing
- Store to `DATA_OUT`: `DataOut` updates at the same rising edge that commits the store (zero added latency).
- Load: `RD` is valid in the same cycle that `Address` is presented, as the single-cycle datapath requires.
- Input change at `DataIn` (before edge k):
  - `s1` updates at edge k.
  - `DATA_IN` reads the new value after edge k+1.
  - `EDGE` is set at edge k+2.
  - `IRQ` rises at edge k+3.
- W1C at edge k: `EDGE` reads 0 after edge k, and `IRQ` drops at edge k+1 unless another enabled bit is still pending.
- Setting `IRQ_EN` on an already-pending bit: `IRQ` rises at the next edge.
- After reset release, the arm counter reaches 3 at the third edge. Rises present after that edge are captured.

## Structure
- Package `pio_pkg` holds:
  - the offset constants `PIO_OFF_DOUT`=2'd0, `PIO_OFF_DIN`=2'd1, `PIO_OFF_EDGE`=2'd2, `PIO_OFF_IEN`=2'd3;
  - the channel stride constant 16.
- Sub-module `pio_channel` (parameter `WIDTH`): one channel's registers, synchroniser, edge logic and per-channel pending flag. It is instantiated `N_CH` times with a generate loop.
- Top level owns the window decode, write demux, read mux, arm counter and `IRQ` register.

## Test plan
- Reset, then read all offsets of every channel: `RD`=0 everywhere, `DataOut`=0, `IRQ`=0. Read at `Address`=0x200: `Hit`=0 and `RD`=0.
- Store 0xFFFF_FFA5 to 0x110 (ch1 `DATA_OUT`): `DataOut[15:8]`=0xA5 after that edge and `DataOut[7:0]` unchanged. A read of 0x110 returns 0x0000_00A5.
- Hold ch0 `DataIn` at 0x00, then drive 0x81 before edge k: `DATA_IN` reads 0x81 after k+1 and `EDGE`(0x108 relative ch0: 0x108 is ch0 edge) reads 0x81 after k+2. With `IRQ_EN`=0, `IRQ` stays 0.
- With ch0 `IRQ_EN`=0x01 and `EDGE`=0x81, `IRQ`=1. Write 0x01 to 0x108: `EDGE`=0x80 and `IRQ`=0 one edge later. Then write 0x80: `EDGE`=0.
- Keep `DataIn` bit 3 high through reset and release reset: `EDGE` stays 0. Toggle the bit low then high: `EDGE` bit 3 is set.
- In the same cycle that a rise on ch0 bit 2 reaches `s2`, W1C bit 2 of ch0 `EDGE`: bit 2 stays 1. Assert `rst` mid-stream: all state is 0 immediately, without waiting for `clk`.
